shift_arb: RTL and testbench
============================

SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
REQ-003 SHALL: req0_valid  input  1  requester 0 has an operation pending.
REQ-004 SHALL: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-005 SHALL: req0_din  input  8  requester 0 operand.
REQ-006 SHALL: req0_shamt  input  3  requester 0 shift amount, 0..7.
REQ-007 SHALL: req0_lr  input  1  requester 0 direction; 1 = left, 0 = right.
REQ-008 SHALL: req0_al  input  1  requester 0 fill mode; 1 = arithmetic, 0 = logical.
REQ-009 SHALL: req1_valid, req1_ready, req1_din, req1_shamt, req1_lr, req1_al  same widths and meanings for requester 1.
REQ-010 SHALL: rsp_valid  output  1  result register holds a result.
REQ-011 SHALL: rsp_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL: rsp_dout  output  8  shifted result.
REQ-013 SHALL: rsp_id  output  1  index of the requester that owns the result.

Function
REQ-014 SHALL: a transfer occurs on any cycle where valid and ready are both 1; the same rule applies on the response side.
REQ-015 SHALL: the block has one result slot; the slot is free when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle.
REQ-016 SHALL: reqN_ready is combinational: 1 only when the slot is free and requester N wins arbitration; at most one ready is high per cycle.
REQ-017 SHALL: arbitration is round-robin over a 1-bit pointer prio; if only one requester is valid, it wins; if both are valid, requester prio wins.
REQ-018 SHALL: after each accepted request, prio becomes the index of the requester that was not granted; prio is unchanged when nothing is accepted.
REQ-019 SHALL: latency is 1 cycle; an operation accepted at edge k drives rsp_valid=1 with its rsp_dout and rsp_id from edge k onward.
REQ-020 SHALL: rsp_dout, rsp_id and rsp_valid hold stable while rsp_valid=1 and rsp_ready=0.
REQ-021 SHALL: rsp_valid falls to 0 after a response transfer with no accept in the same cycle; with an accept in the same cycle, it stays 1 and the slot is reloaded (full throughput, one operation per cycle).
REQ-022 SHALL: a right shift with al=0 fills vacated bits with 0.
REQ-023 SHALL: a right shift with al=1 fills vacated bits with din[7].
REQ-024 SHALL: a left shift fills vacated bits with 0 regardless of al.
REQ-025 SHALL: shamt=0 returns din unchanged for every lr and al.
REQ-026 SHALL: the shift computation is purely combinational on the granted operand and is captured only into the result register.
REQ-027 SHALL: the block has no starvation; with both requesters continuously valid and rsp_ready=1, grants alternate 0,1,0,1 or 1,0,1,0.

Reset
REQ-028 SHALL: while rst_n=0 at a clock edge: rsp_valid=0, rsp_dout=8'h00, rsp_id=0, prio=0.
REQ-029 SHALL: req0_ready=req1_ready=0 on any cycle where rst_n=0.
REQ-030 SHALL: a reset asserted while a result is pending discards that result; no response transfer is reported for it.

Structure
REQ-031 SHALL: a shared package holds the operation-field widths (DATA_W=8, SHAMT_W=3) and the direction and fill encodings (DIR_LEFT=1, FILL_ARITH=1).
REQ-032 SHALL: the datapath is one sub-module, barrel_shift8: combinational, with inputs din, shamt, lr, al and output dout; shift_arb instantiates exactly one of it, shared through a grant mux.

Verification
REQ-033 SHALL: reset, then req0 {din=8'hB4, shamt=2, lr=0, al=1} with rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_dout=8'hED, rsp_id=0.
REQ-034 SHALL: both valid with prio=0; req0 {8'h81, 1, left, al=1}, req1 {8'h81, 3, right, al=0} -> rsp_dout sequence 8'h02 (id 0), then 8'h10 (id 1).
REQ-035 SHALL: rsp_ready=0 for 3 cycles holding result 8'h5A -> rsp_valid/rsp_dout/rsp_id stable; both reqN_ready=0 throughout; first grant follows the cycle rsp_ready rises.
REQ-036 SHALL: both requesters continuously valid, rsp_ready=1 for 8 cycles -> 8 responses, rsp_id alternating, no bubble cycles.
REQ-037 SHALL: rst_n=0 while rsp_valid=1 -> next cycle rsp_valid=0, rsp_dout=8'h00, and the next grant goes to requester 0 when both are valid.
REQ-038 SHALL: shamt=0 sweep over all lr/al values with din=8'h96 -> rsp_dout=8'h96 in every case; shamt=7, right, al=1, din=8'h80 -> 8'hFF.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// rtl/shift_arb_pkg.sv - operation field widths, encodings and operation record for shift_arb
package shift_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  localparam logic DIR_LEFT   = 1'b1;
  localparam logic FILL_ARITH = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0]  din;
    logic [SHAMT_W-1:0] shamt;
    logic               lr;
    logic               al;
  } shift_op_t;

endpackage

// File: rtl/barrel_shift8.sv
// rtl/barrel_shift8.sv - combinational 8-bit log barrel shifter, left or right, logical or arithmetic
module barrel_shift8
  import shift_arb_pkg::*;
(
  input  logic [DATA_W-1:0]  din,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               lr,
  input  logic               al,
  output logic [DATA_W-1:0]  dout
);

  logic              w_left;
  logic              w_fill;
  logic [DATA_W-1:0] w_s1;
  logic [DATA_W-1:0] w_s2;
  logic [DATA_W-1:0] w_s3;

  assign w_left = (lr == DIR_LEFT);
  // Only an arithmetic right shift replicates the sign bit; left shifts always fill with 0.
  assign w_fill = !w_left && (al == FILL_ARITH) && din[7];

  always_comb begin
    w_s1 = din;
    if (shamt[0]) w_s1 = w_left ? {din[6:0], 1'b0} : {w_fill, din[7:1]};
    w_s2 = w_s1;
    if (shamt[1]) w_s2 = w_left ? {w_s1[5:0], 2'b00} : {{2{w_fill}}, w_s1[7:2]};
    w_s3 = w_s2;
    if (shamt[2]) w_s3 = w_left ? {w_s2[3:0], 4'h0} : {{4{w_fill}}, w_s2[7:4]};
  end

  assign dout = w_s3;

endmodule

// File: rtl/shift_arb.sv
// rtl/shift_arb.sv - two-requester round-robin arbiter sharing one barrel shifter and one result slot
module shift_arb
  import shift_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_din,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_lr,
  input  logic               req0_al,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_din,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_lr,
  input  logic               req1_al,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_dout,
  output logic               rsp_id
);

  logic              r_valid;
  logic [DATA_W-1:0] r_dout;
  logic              r_id;
  logic              r_prio;

  logic              w_slot_free;
  logic              w_grant0;
  logic              w_grant1;
  logic              w_sel;
  logic              w_accept;
  shift_op_t         w_op0;
  shift_op_t         w_op1;
  shift_op_t         w_op;
  logic [DATA_W-1:0] w_shifted;

  // The slot can be refilled in the same cycle its current result leaves.
  assign w_slot_free = !r_valid || rsp_ready;

  assign w_grant0 = req0_valid && (!req1_valid || (r_prio == 1'b0));
  assign w_grant1 = req1_valid && (!req0_valid || (r_prio == 1'b1));

  assign req0_ready = rst_n && w_slot_free && w_grant0;
  assign req1_ready = rst_n && w_slot_free && w_grant1;
  assign w_accept   = req0_ready || req1_ready;
  assign w_sel      = w_grant1;

  assign w_op0 = '{din: req0_din, shamt: req0_shamt, lr: req0_lr, al: req0_al};
  assign w_op1 = '{din: req1_din, shamt: req1_shamt, lr: req1_lr, al: req1_al};
  assign w_op  = w_sel ? w_op1 : w_op0;

  barrel_shift8 u_shift (
    .din   (w_op.din),
    .shamt (w_op.shamt),
    .lr    (w_op.lr),
    .al    (w_op.al),
    .dout  (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_id    <= 1'b0;
      r_prio  <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_dout  <= w_shifted;
      r_id    <= w_sel;
      r_prio  <= ~w_sel;
    end else if (rsp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_valid;
  assign rsp_dout  = r_dout;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_shift_arb.sv
// tb/tb_shift_arb.sv - directed self-checking bench for shift_arb
module tb_shift_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_lr, req0_al;
  logic [7:0] req0_din;
  logic [2:0] req0_shamt;
  logic       req1_valid, req1_ready, req1_lr, req1_al;
  logic [7:0] req1_din;
  logic [2:0] req1_shamt;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_dout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  shift_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_din   (req0_din),
    .req0_shamt (req0_shamt),
    .req0_lr    (req0_lr),
    .req0_al    (req0_al),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_din   (req1_din),
    .req1_shamt (req1_shamt),
    .req1_lr    (req1_lr),
    .req1_al    (req1_al),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_dout   (rsp_dout),
    .rsp_id     (rsp_id)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic [2:0] s, input logic lr, input logic al);
    req0_valid = v; req0_din = d; req0_shamt = s; req0_lr = lr; req0_al = al;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic [2:0] s, input logic lr, input logic al);
    req1_valid = v; req1_din = d; req1_shamt = s; req1_lr = lr; req1_al = al;
  endtask

  typedef struct {
    logic [7:0] din;
    logic [2:0] shamt;
    logic       lr;
    logic       al;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h96, 3'd0, 1'b0, 1'b0, 8'h96};
    vecs[1] = '{8'h96, 3'd0, 1'b0, 1'b1, 8'h96};
    vecs[2] = '{8'h96, 3'd0, 1'b1, 1'b0, 8'h96};
    vecs[3] = '{8'h96, 3'd0, 1'b1, 1'b1, 8'h96};
    vecs[4] = '{8'h80, 3'd7, 1'b0, 1'b1, 8'hFF};
    vecs[5] = '{8'hFF, 3'd3, 1'b1, 1'b1, 8'hF8};
    vecs[6] = '{8'hF0, 3'd4, 1'b0, 1'b0, 8'h0F};
    vecs[7] = '{8'h6C, 3'd5, 1'b0, 1'b1, 8'h03};

    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set0(1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    set1(1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_dout", rsp_dout, 8'h00);
    check("rst_id", rsp_id, 1'b0);
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);

    // single arithmetic right shift
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b1, 8'hB4, 3'd2, 1'b0, 1'b1);
    set1(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    check("t1_ready0", req0_ready, 1'b1);
    check("t1_ready1", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t1_valid", rsp_valid, 1'b1);
    check("t1_dout", rsp_dout, 8'hED);
    check("t1_id", rsp_id, 1'b0);
    // lone requester 1 wins and returns prio to 0
    set0(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    set1(1'b1, 8'h3C, 3'd1, 1'b1, 1'b0);
    #1;
    check("t1b_ready1", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("t1b_dout", rsp_dout, 8'h78);
    check("t1b_id", rsp_id, 1'b1);

    // both valid with prio=0
    set0(1'b1, 8'h81, 3'd1, 1'b1, 1'b1);
    set1(1'b1, 8'h81, 3'd3, 1'b0, 1'b0);
    #1;
    check("t2_ready0", req0_ready, 1'b1);
    check("t2_ready1", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t2_dout0", rsp_dout, 8'h02);
    check("t2_id0", rsp_id, 1'b0);
    check("t2_ready1b", req1_ready, 1'b1);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t2_dout1", rsp_dout, 8'h10);
    check("t2_id1", rsp_id, 1'b1);
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t2_drain", rsp_valid, 1'b0);

    // backpressure holds the slot
    set0(1'b1, 8'h5A, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    set1(1'b1, 8'h0F, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_valid", rsp_valid, 1'b1);
      check("t3_dout", rsp_dout, 8'h5A);
      check("t3_id", rsp_id, 1'b0);
      check("t3_ready0", req0_ready, 1'b0);
      check("t3_ready1", req1_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("t3_rel_ready1", req1_ready, 1'b1);
    check("t3_rel_ready0", req0_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t3_dout_next", rsp_dout, 8'hF0);
    check("t3_id_next", rsp_id, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // full throughput alternation
    set0(1'b1, 8'h01, 3'd1, 1'b1, 1'b0);
    set1(1'b1, 8'h80, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("t4_valid", rsp_valid, 1'b1);
      check("t4_id", rsp_id, (i % 2 == 0) ? 1'b0 : 1'b1);
      check("t4_dout", rsp_dout, (i % 2 == 0) ? 8'h02 : 8'h40);
    end
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_pre_id", rsp_id, 1'b0);

    // reset while a result is pending
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t5_valid", rsp_valid, 1'b0);
    check("t5_dout", rsp_dout, 8'h00);
    set0(1'b1, 8'h01, 3'd0, 1'b0, 1'b0);
    set1(1'b1, 8'h02, 3'd0, 1'b0, 1'b0);
    #1;
    check("t5_rst_ready0", req0_ready, 1'b0);
    check("t5_rst_ready1", req1_ready, 1'b0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("t5_grant0", req0_ready, 1'b1);
    check("t5_grant1", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("t5_dout", rsp_dout, 8'h01);
    req1_valid = 1'b0;

    // shifter table through requester 0
    for (int i = 0; i < 8; i++) begin
      set0(1'b1, vecs[i].din, vecs[i].shamt, vecs[i].lr, vecs[i].al);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t6_vec%0d", i), rsp_dout, vecs[i].exp);
    end
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_drain", rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
